// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

  localparam int UART_OFS_DATA   = 0;
  localparam int UART_OFS_STATUS = 1;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } uart_state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for the UART transmitter: read-before-write, so a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic          wr_en;
  logic          rd_en;

  // Extra pointer bit separates "full" (wrapped once) from "empty".
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: DATA/STATUS window, TX FIFO and serial FSM.
// Define UART_TX_PARITY_EN for 8E1 frames (default build sends 8N1).
module uart_tx_port
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_sel,
  output logic        tx,
  output logic        busy
);

  localparam int          BW          = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [15:0] DATA_ADDR   = BASE_ADDR + 16'(UART_OFS_DATA);
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'(UART_OFS_STATUS);

  uart_state_t   state_reg, state_next;
  logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          ovf_reg, ovf_next;
  logic [15:0]   d_rdata_reg;
  logic          d_sel_reg;
`ifdef UART_TX_PARITY_EN
  logic          parity_reg, parity_next;
`endif

  logic        hit_data, hit_status, push, fifo_pop, overflow, bit_done;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [15:0] status_word;
  logic        unused_wdata;

  assign hit_data     = (d_addr == DATA_ADDR);
  assign hit_status   = (d_addr == STATUS_ADDR);
  assign push         = memory_write & hit_data;
  assign fifo_pop     = (state_reg == S_IDLE) & ~fifo_empty;
  assign overflow     = push & fifo_full & ~fifo_pop;
  assign bit_done     = (baud_cnt_reg == BAUD_LAST);
  assign unused_wdata = ^d_wdata[15:8];

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .din   (d_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status_word            = '0;
    status_word[ST_FULL]   = fifo_full;
    status_word[ST_EMPTY]  = fifo_empty;
    status_word[ST_ACTIVE] = (state_reg != S_IDLE);
    status_word[ST_OVF]    = ovf_reg;
  end

  // Set beats the read-clear when both land in the same cycle.
  always_comb begin
    ovf_next = ovf_reg;
    if (memory_read && hit_status) ovf_next = 1'b0;
    if (overflow)                  ovf_next = 1'b1;
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_next       = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_next    = S_START;
          shift_next    = fifo_dout;
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
`ifdef UART_TX_PARITY_EN
          parity_next   = even_parity(fifo_dout);
`endif
        end
      end
      S_START: begin
        tx_next = 1'b0;
        if (bit_done) begin
          state_next    = S_DATA;
          baud_cnt_next = '0;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        tx_next = shift_reg[0];
        if (bit_done) begin
          baud_cnt_next = '0;
          shift_next    = shift_reg >> 1;
          bit_cnt_next  = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_next = parity_reg;
        if (bit_done) begin
          state_next    = S_STOP;
          baud_cnt_next = '0;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_next = 1'b1;
        if (bit_done) begin
          state_next    = S_IDLE;
          baud_cnt_next = '0;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next    = S_IDLE;
        baud_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      ovf_reg      <= 1'b0;
      d_rdata_reg  <= '0;
      d_sel_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      ovf_reg      <= ovf_next;
      d_sel_reg    <= memory_read & (hit_data | hit_status);
      d_rdata_reg  <= (memory_read && hit_status) ? status_word : 16'h0000;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  assign tx      = tx_reg;
  assign d_rdata = d_rdata_reg;
  assign d_sel   = d_sel_reg;
  assign busy    = (state_reg != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: waveform, FIFO/overflow, bus timing and reset.
// Follows UART_TX_PARITY_EN to pick the expected frame length.
module tb_uart_tx_port;

  localparam int          CPB  = 4;
  localparam logic [15:0] BASE = 16'hFF00;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_wdata = 16'h0000;
  logic [15:0] d_rdata;
  logic        d_sel;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] rx_bytes[$];
  int         rx_starts[$];

  uart_tx_port #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .memory_read (memory_read),
    .memory_write(memory_write),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_sel       (d_sel),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Expected line level for bit slot k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == FRAME_BITS - 1) return 1'b1;
    return ^b;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b, required 0 within 1000 cycles", busy);
    end
  endtask

  task automatic read_status(output logic sel, output logic [15:0] data);
    @(negedge clk);
    memory_read = 1'b1;
    d_addr      = BASE + 16'd1;
    @(negedge clk);
    memory_read = 1'b0;
    sel  = d_sel;
    data = d_rdata;
  endtask

  // UART receiver: mid-bit sampling of n frames into rx_bytes/rx_starts.
  task automatic capture_frames(input int n);
    int         t;
    logic [7:0] b;
    logic       ok;
    rx_bytes.delete();
    rx_starts.delete();
    for (int f = 0; f < n; f++) begin
      t = 0;
      @(negedge clk);
      while (tx !== 1'b0 && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (tx !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_timeout frame %0d: tx=%b, required a start bit", f, tx);
        return;
      end
      rx_starts.push_back(cyc);
      repeat (CPB / 2) @(negedge clk);
      ok = (tx === 1'b0);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      ok = ok & (tx === ^b);
`endif
      repeat (CPB) @(negedge clk);
      ok = ok & (tx === 1'b1);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rx_framing frame %0d byte %h: start/parity/stop malformed, required well-formed frame", f, b);
      end
      rx_bytes.push_back(b);
    end
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp_q[$]);
    n_checks++;
    if (rx_bytes.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d frames, required %0d", name, rx_bytes.size(), exp_q.size());
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_bytes[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_byte[%0d]: got %h, required %h", name, i, rx_bytes[i], exp_q[i]);
      end
      if (i > 0) begin
        n_checks++;
        if (rx_starts[i] - rx_starts[i-1] != FRAME_CYC + 1) begin
          n_fail++;
          $display("FAIL %s_gap[%0d]: start spacing %0d cycles, required %0d", name, i,
                   rx_starts[i] - rx_starts[i-1], FRAME_CYC + 1);
        end
      end
    end
    $display("%s: %0d frames received", name, rx_bytes.size());
  endtask

  task automatic test_reset();
    logic        sel;
    logic [15:0] data;
    repeat (2) @(negedge clk);
    memory_write = 1'b1;
    d_addr       = BASE;
    d_wdata      = 16'h00AA;
    @(negedge clk);
    memory_write = 1'b0;
    n_checks += 4;
    if (tx !== 1'b1)          begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
    if (d_sel !== 1'b0)       begin n_fail++; $display("FAIL reset_d_sel: got %b, required 0", d_sel); end
    if (d_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_d_rdata: got %h, required 0000", d_rdata); end
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b0;
    read_status(sel, data);
    n_checks++;
    if (sel !== 1'b1 || data !== 16'h0002) begin
      n_fail++;
      $display("FAIL reset_status: sel=%b data=%h, required sel=1 data=0002", sel, data);
    end
    $display("reset: status after release %h", data);
  endtask

  task automatic test_single_byte(input logic [7:0] b);
    logic exp;
    int   errs;
    errs = 0;
    wait_idle();
    @(negedge clk);
    memory_write = 1'b1;
    d_addr       = BASE;
    d_wdata      = {8'($urandom), b};
    @(negedge clk);
    memory_write = 1'b0;
    for (int i = 0; i < FRAME_CYC + 6; i++) begin
      if (i > 0) @(negedge clk);
      exp = (i < 2 || i >= 2 + FRAME_CYC) ? 1'b1 : frame_bit(b, (i - 2) / CPB);
      n_checks++;
      if (tx !== exp) begin
        n_fail++;
        errs++;
        $display("FAIL wave_%h[%0d]: tx=%b, required %b", b, i, tx, exp);
      end
      if (i == 1 || i == FRAME_CYC + 5) begin
        n_checks++;
        if (busy !== (i == 1)) begin
          n_fail++;
          $display("FAIL busy_%h[%0d]: got %b, required %b", b, i, busy, (i == 1));
        end
      end
    end
    $display("single byte %h: %0d waveform errors", b, errs);
  endtask

  task automatic test_read_timing();
    logic [15:0] other;
    wait_idle();
    @(negedge clk);
    memory_read = 1'b1;
    d_addr      = BASE + 16'd1;
    #1;
    n_checks++;
    if (d_sel !== 1'b0) begin n_fail++; $display("FAIL rd_early_sel: got %b, required 0", d_sel); end
    @(negedge clk);
    memory_read = 1'b0;
    n_checks++;
    if (d_sel !== 1'b1 || d_rdata !== 16'h0002) begin
      n_fail++;
      $display("FAIL rd_status: sel=%b data=%h, required sel=1 data=0002", d_sel, d_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (d_sel !== 1'b0) begin n_fail++; $display("FAIL rd_pulse: d_sel=%b, required 0", d_sel); end
    memory_read = 1'b1;
    d_addr      = BASE + 16'd2;
    @(negedge clk);
    memory_read = 1'b0;
    n_checks++;
    if (d_sel !== 1'b0) begin n_fail++; $display("FAIL rd_miss_ff02: d_sel=%b, required 0", d_sel); end
    memory_read = 1'b1;
    d_addr      = BASE;
    @(negedge clk);
    memory_read = 1'b0;
    n_checks++;
    if (d_sel !== 1'b1 || d_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL rd_data_reg: sel=%b data=%h, required sel=1 data=0000", d_sel, d_rdata);
    end
    other = 16'($urandom_range(0, 16'hFEFF));
    memory_read = 1'b1;
    d_addr      = other;
    @(negedge clk);
    memory_read = 1'b0;
    n_checks++;
    if (d_sel !== 1'b0) begin n_fail++; $display("FAIL rd_miss_%h: d_sel=%b, required 0", other, d_sel); end
    $display("read timing: checked status, data, and misses FF02/%h", other);
  endtask

  task automatic test_overflow();
    logic [7:0]  exp_q[$];
    logic        sel;
    logic [15:0] data;
    wait_idle();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          memory_write = 1'b1;
          d_addr       = BASE;
          d_wdata      = 16'(i + 1);
        end
        @(negedge clk);
        memory_write = 1'b0;
        memory_read  = 1'b1;
        d_addr       = BASE + 16'd1;
        @(negedge clk);
        n_checks++;
        if (d_sel !== 1'b1 || d_rdata !== 16'h000D) begin
          n_fail++;
          $display("FAIL ovf_status1: sel=%b data=%h, required sel=1 data=000D", d_sel, d_rdata);
        end
        @(negedge clk);
        memory_read = 1'b0;
        n_checks++;
        if (d_sel !== 1'b1 || d_rdata !== 16'h0005) begin
          n_fail++;
          $display("FAIL ovf_status2: sel=%b data=%h, required sel=1 data=0005", d_sel, d_rdata);
        end
      end
      capture_frames(5);
    join
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(i + 1));
    check_rx("overflow", exp_q);
    wait_idle();
    read_status(sel, data);
    n_checks++;
    if (data !== 16'h0002) begin
      n_fail++;
      $display("FAIL ovf_after: status=%h, required 0002 (dropped byte must not be sent)", data);
    end
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] b[6];
    logic [7:0] exp_q[$];
    int         w1;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    wait_idle();
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i == 0) w1 = cyc + 1;
          memory_write = 1'b1;
          d_addr       = BASE;
          d_wdata      = {8'h00, b[i]};
        end
        @(negedge clk);
        memory_write = 1'b0;
        // Next pop lands on edge w1+1+FRAME_CYC+1; present the write for that edge.
        while (cyc < w1 + FRAME_CYC + 1) @(negedge clk);
        memory_write = 1'b1;
        d_wdata      = {8'h00, b[5]};
        @(negedge clk);
        memory_write = 1'b0;
        memory_read  = 1'b1;
        d_addr       = BASE + 16'd1;
        @(negedge clk);
        memory_read = 1'b0;
        n_checks++;
        if (d_sel !== 1'b1 || d_rdata !== 16'h0005) begin
          n_fail++;
          $display("FAIL pushpop_status: sel=%b data=%h, required sel=1 data=0005", d_sel, d_rdata);
        end
      end
      capture_frames(6);
    join
    for (int i = 0; i < 6; i++) exp_q.push_back(b[i]);
    check_rx("push_pop", exp_q);
  endtask

  task automatic test_random_burst();
    logic [7:0]  b[6];
    logic [7:0]  exp_q[$];
    logic        sel;
    logic [15:0] data;
    int          n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      exp_q.delete();
      for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
      for (int i = 0; i < n && i < 5; i++) exp_q.push_back(b[i]);
      wait_idle();
      fork
        begin
          for (int i = 0; i < n; i++) begin
            @(negedge clk);
            memory_write = 1'b1;
            d_addr       = BASE;
            d_wdata      = {8'($urandom), b[i]};
          end
          @(negedge clk);
          memory_write = 1'b0;
        end
        capture_frames(exp_q.size());
      join
      check_rx("burst", exp_q);
      wait_idle();
      read_status(sel, data);
      n_checks++;
      if (data !== (n > 5 ? 16'h000A : 16'h0002)) begin
        n_fail++;
        $display("FAIL burst_status n=%0d: got %h, required %h", n, data, (n > 5 ? 16'h000A : 16'h0002));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0]  b0, b1;
    logic [7:0]  exp_q[$];
    logic        sel;
    logic [15:0] data;
    int          t;
    b0 = 8'($urandom) & 8'hFD;
    b1 = 8'($urandom);
    wait_idle();
    @(negedge clk);
    memory_write = 1'b1;
    d_addr       = BASE;
    d_wdata      = {8'h00, b0};
    @(negedge clk);
    memory_write = 1'b0;
    t = 0;
    while (tx !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (9) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_pre: tx=%b, required 0 (data bit1)", tx); end
    #1 rst = 1'b1;
    #1;
    n_checks += 3;
    if (tx !== 1'b1)    begin n_fail++; $display("FAIL async_rst_tx: got %b, required 1", tx); end
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL async_rst_busy: got %b, required 0", busy); end
    if (d_sel !== 1'b0) begin n_fail++; $display("FAIL async_rst_sel: got %b, required 0", d_sel); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_status(sel, data);
    n_checks++;
    if (sel !== 1'b1 || data !== 16'h0002) begin
      n_fail++;
      $display("FAIL midframe_status: sel=%b data=%h, required sel=1 data=0002", sel, data);
    end
    fork
      begin
        @(negedge clk);
        memory_write = 1'b1;
        d_addr       = BASE;
        d_wdata      = {8'h00, b1};
        @(negedge clk);
        memory_write = 1'b0;
      end
      capture_frames(1);
    join
    exp_q.push_back(b1);
    check_rx("after_reset", exp_q);
  endtask

  initial begin
    test_reset();
    test_read_timing();
    test_single_byte(8'hA5);
    test_single_byte(8'h07);
    test_single_byte(8'h03);
    test_single_byte(8'($urandom));
    test_overflow();
    test_simul_push_pop();
    test_random_burst();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
